// File: rtl/conv33_pkg.sv
// Shared types and defaults for the conv33 result read path.
package conv33_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } conv33_state_e;

  localparam int unsigned OutWidthDefault = 32;
  localparam int unsigned ImgWDefault     = 26;
  localparam int unsigned ImgHDefault     = 26;
  localparam int unsigned FifoDepthDefault = 4;

endpackage

// File: rtl/conv33_tag_fifo.sv
// Small synchronous FIFO holding tagged result words ({last,row,col,data}).
// The head word reads as zero while the FIFO is empty.
module conv33_tag_fifo #(
  parameter int unsigned WIDTH = 43,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= push_data;
  end

  // Occupancy next-state; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Head word, zeroed while empty so downstream sees clean outputs.
  always_comb begin
    head_data = '0;
    if (!empty) head_data = mem[rptr_q];
  end

endmodule

// File: rtl/conv33_result_reader.sv
// Read-side controller for the conv33 output buffer: throttled reads, row/col
// tagging of returned results and a valid/ready result stream.
module conv33_result_reader
  import conv33_pkg::*;
#(
  parameter int unsigned OUT_WIDTH  = OutWidthDefault,
  parameter int unsigned IMG_W      = ImgWDefault,
  parameter int unsigned IMG_H      = ImgHDefault,
  parameter int unsigned FIFO_DEPTH = FifoDepthDefault
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     read_en,
  input  logic                     buf_valid,
  input  logic [OUT_WIDTH-1:0]     buf_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OUT_WIDTH-1:0]     m_data,
  output logic [$clog2(IMG_H)-1:0] m_row,
  output logic [$clog2(IMG_W)-1:0] m_col,
  output logic                     m_last,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned RowW  = $clog2(IMG_H);
  localparam int unsigned ColW  = $clog2(IMG_W);
  localparam int unsigned Total = IMG_W * IMG_H;
  localparam int unsigned CntW  = $clog2(Total + 1);
  localparam int unsigned FcW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WordW = 1 + RowW + ColW + OUT_WIDTH;

  localparam logic [RowW-1:0] RowMax = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0] ColMax = ColW'(IMG_W - 1);

  conv33_state_e   state_q, state_d;
  logic [CntW-1:0] accepted_q;
  logic [RowW-1:0] row_q;
  logic [ColW-1:0] col_q;
  logic            inflight_q;
  logic            capture;
  logic            fifo_room, frame_room;
  logic [FcW-1:0]  fifo_count;
  logic            fifo_empty;
  logic [WordW-1:0] push_word, head_word;

  // A read is issued only if its response is guaranteed a FIFO slot and the
  // frame still needs results beyond those already requested.
  assign fifo_room  = ({1'b0, fifo_count} + (FcW + 1)'(inflight_q)) < (FcW + 1)'(FIFO_DEPTH);
  assign frame_room = (accepted_q + CntW'(inflight_q)) < CntW'(Total);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (accepted_q == CntW'(Total)) state_d = StDrain;
      StDrain: if (fifo_empty) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode.
  always_comb begin
    read_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StRun: begin
        read_en = fifo_room && frame_room;
        busy    = 1'b1;
        capture = buf_valid;
      end
      StDrain: begin
        busy    = 1'b1;
        capture = buf_valid;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Capture counters and the one-cycle read-in-flight flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accepted_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= read_en;
      if (state_q == StIdle && start) begin
        accepted_q <= '0;
        row_q      <= '0;
        col_q      <= '0;
      end else if (capture) begin
        accepted_q <= accepted_q + CntW'(1);
        if (col_q == ColMax) begin
          col_q <= '0;
          row_q <= row_q + RowW'(1);
        end else begin
          col_q <= col_q + ColW'(1);
        end
      end
    end
  end

  assign push_word = {(row_q == RowMax) && (col_q == ColMax), row_q, col_q, buf_data};

  conv33_tag_fifo #(
    .WIDTH (WordW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (push_word),
    .pop       (m_valid && m_ready),
    .head_data (head_word),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_valid = !fifo_empty;
  assign {m_last, m_row, m_col, m_data} = head_word;

endmodule

// File: tb/tb_conv33_result_reader.sv
// Directed bench for conv33_result_reader with a behavioural output-buffer model.
module tb_conv33_result_reader;

  localparam int Total = 676;
  localparam int Depth = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        read_en;
  logic        buf_valid;
  logic [31:0] buf_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic [4:0]  m_row;
  logic [4:0]  m_col;
  logic        m_last;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  // Buffer model state
  int       mode = 0;        // 0: always respond, 1: respond to 1 of 3 reads
  int       req_cnt = 0;
  int       resp_idx = 0;
  int       resp_total = 0;
  logic [7:0] frame_id = 8'd0;

  // Monitor state
  int k = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int ovf_cnt = 0;

  conv33_result_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .read_en   (read_en),
    .buf_valid (buf_valid),
    .buf_data  (buf_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_row     (m_row),
    .m_col     (m_col),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output buffer: answers a read_en one cycle later with a frame/index tagged word.
  initial begin
    logic req, give;
    buf_valid = 1'b0;
    buf_data  = '0;
    forever begin
      @(negedge clk);
      req = read_en && !rst;
      @(posedge clk);
      #1;
      give = 1'b0;
      if (req) begin
        req_cnt++;
        give = (mode == 0) || (req_cnt % 3 == 1);
      end
      buf_valid = give;
      if (give) begin
        buf_data = {frame_id, 24'(resp_idx)};
        resp_idx++;
        resp_total++;
      end
    end
  end

  // Stream monitor: each accepted beat must carry the next tag and data in sequence.
  always @(negedge clk) begin
    logic [42:0] exp;
    if (!rst) begin
      if (done) done_cnt++;
      if (read_en) rd_cnt++;
      if (buf_valid && busy && dut.fifo_count == 3'(Depth)) ovf_cnt++;
      if (m_valid && m_ready) begin
        exp = {k == Total - 1, 5'(k / 26), 5'(k % 26), frame_id, 24'(k)};
        check_eq("beat", 64'({m_last, m_row, m_col, m_data}), 64'(exp));
        k++;
      end
    end
  end

  task automatic start_frame(input logic [7:0] id);
    @(posedge clk);
    #1;
    frame_id = id;
    resp_idx = 0;
    k = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(done === 1'b1), 64'd1);
  endtask

  // After DONE: one done pulse for the frame, full result count, back in IDLE.
  task automatic finish_frame(input string tag, input int done_before);
    @(negedge clk);
    check_eq({tag, "_count"}, 64'(k), 64'(Total));
    check_eq({tag, "_done_once"}, 64'(done_cnt - done_before), 64'd1);
    check_eq({tag, "_idle"}, 64'({busy, done, read_en, m_valid}), 64'd0);
  endtask

  initial begin
    int d0, r0, n;
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_outs", 64'({read_en, m_valid, m_data, m_row, m_col, m_last, busy, done}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", 64'(busy), 64'd0);
    check_eq("idle_read_en", 64'(read_en), 64'd0);

    // Frame 1: always-full buffer, ready high; also first-result latency
    d0 = done_cnt;
    start_frame(8'd1);
    check_eq("run_busy", 64'(busy), 64'd1);
    n = 0;
    @(negedge clk);
    while (buf_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("first_resp_seen", 64'(buf_valid), 64'd1);
    check_eq("lat_before", 64'(m_valid), 64'd0);
    @(negedge clk);
    check_eq("lat_after", 64'(m_valid), 64'd1);
    wait_done(3000, "f1_done");
    finish_frame("f1", d0);

    // Frame 2: downstream stall for 20 cycles mid-frame
    d0 = done_cnt;
    start_frame(8'd2);
    repeat (100) @(negedge clk);
    @(posedge clk);
    #1 m_ready = 1'b0;
    r0 = resp_total;
    repeat (20) @(negedge clk);
    check_eq("stall_read_off", 64'(read_en), 64'd0);
    check_eq("stall_valid_held", 64'(m_valid), 64'd1);
    check_eq("stall_resp_bound", 64'((resp_total - r0) <= Depth), 64'd1);
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_done(3000, "f2_done");
    finish_frame("f2", d0);

    // Frame 3: buffer answers only one read in three
    mode = 1;
    d0 = done_cnt;
    r0 = rd_cnt;
    start_frame(8'd3);
    wait_done(8000, "f3_done");
    check_eq("f3_polling", 64'((rd_cnt - r0) >= 3 * Total - 3), 64'd1);
    finish_frame("f3", d0);
    mode = 0;

    // Frame 4: start pulsed again while running is ignored
    d0 = done_cnt;
    start_frame(8'd4);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_eq("f4_still_busy", 64'(busy), 64'd1);
    wait_done(3000, "f4_done");
    finish_frame("f4", d0);

    // Frame 5: reset around result 300 with entries queued
    start_frame(8'd5);
    n = 0;
    while (k < 297 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("f5_reached", 64'(k >= 297), 64'd1);
    @(posedge clk);
    #1 m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("abort_outs",
             64'({read_en, m_valid, m_data, m_row, m_col, m_last, busy, done}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("abort_fifo_empty", 64'(m_valid), 64'd0);
    check_eq("abort_idle", 64'(busy), 64'd0);

    // Frame 6: a fresh frame after the abort starts from (0,0)
    d0 = done_cnt;
    start_frame(8'd6);
    wait_done(3000, "f6_done");
    finish_frame("f6", d0);

    check_eq("no_overflow", 64'(ovf_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
